// File: rtl/mips_dmem_bytelane.sv
// rtl/mips_dmem_bytelane.sv - big-endian byte/half/word data memory with fault detection and counting
module mips_dmem_bytelane #(
    parameter int DEPTH = 64,
    parameter int ERR_W = 11
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     we,
    input  logic [1:0]               size,
    input  logic                     uns,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     rvalid,
    output logic                     fault,
    output logic [1:0]               fcode,
    output logic [ERR_W-1:0]         err_count,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [31:0]              dbg_word
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_RANGE    = 2'b10;
    localparam logic [1:0] FC_SIZE     = 2'b11;

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] widx;
    logic [1:0]    off;
    logic [31:0]   cur_word;

    logic          bad_size;
    logic          out_range;
    logic          misaligned;
    logic          any_fault;
    logic [1:0]    fc_next;

    logic [3:0]    lane_mask;
    logic [31:0]   lane_data;
    logic [31:0]   store_word;

    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_word;

    assign widx     = addr[AW+1:2];
    assign off      = addr[1:0];
    assign cur_word = mem[widx];
    assign dbg_word = mem[dbg_addr];

    // Fault classification; bad size outranks range, range outranks alignment.
    always_comb begin
        bad_size   = (size == 2'b11);
        out_range  = |addr[31:AW+2];
        misaligned = 1'b0;
        case (size)
            SZ_HALF: misaligned = addr[0];
            SZ_WORD: misaligned = |addr[1:0];
            default: misaligned = 1'b0;
        endcase
        any_fault = bad_size | out_range | misaligned;
        if (bad_size) begin
            fc_next = FC_SIZE;
        end else if (out_range) begin
            fc_next = FC_RANGE;
        end else begin
            fc_next = FC_MISALIGN;
        end
    end

    // Store merge: lane_mask bit 3 is bits 31:24, i.e. byte offset 0.
    always_comb begin
        lane_mask = 4'b0000;
        lane_data = wdata;
        case (size)
            SZ_BYTE: begin
                lane_data = {4{wdata[7:0]}};
                case (off)
                    2'd0:    lane_mask = 4'b1000;
                    2'd1:    lane_mask = 4'b0100;
                    2'd2:    lane_mask = 4'b0010;
                    default: lane_mask = 4'b0001;
                endcase
            end
            SZ_HALF: begin
                lane_data = {2{wdata[15:0]}};
                lane_mask = off[1] ? 4'b0011 : 4'b1100;
            end
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
        store_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) begin
                store_word[8*i +: 8] = lane_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        case (off)
            2'd0:    byte_sel = cur_word[31:24];
            2'd1:    byte_sel = cur_word[23:16];
            2'd2:    byte_sel = cur_word[15:8];
            default: byte_sel = cur_word[7:0];
        endcase
        half_sel = off[1] ? cur_word[15:0] : cur_word[31:16];
        case (size)
            SZ_BYTE: load_word = {{24{~uns & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_word = {{16{~uns & half_sel[15]}}, half_sel};
            default: load_word = cur_word;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata     <= '0;
            rvalid    <= 1'b0;
            fault     <= 1'b0;
            fcode     <= 2'b00;
            err_count <= '0;
        end else begin
            rvalid <= 1'b0;
            fault  <= 1'b0;
            if (en) begin
                if (any_fault) begin
                    rdata <= '0;
                    fault <= 1'b1;
                    fcode <= fc_next;
                    if (err_count != ERR_MAX) begin
                        err_count <= err_count + 1'b1;
                    end
                end else if (we) begin
                    mem[widx] <= store_word;
                end else begin
                    rdata  <= load_word;
                    rvalid <= 1'b1;
                end
            end
        end
    end

endmodule
